// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: print FIFO plus an 80x60 cursor tracker that issues single-cell writes to the text store.
// Define TEXT_CTRLCODE_EN to decode 6'h3D/3E/3F as clear, backspace and newline; otherwise all codes print.
module text_cursor_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = 6
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          print_valid,
    input  logic [CW-1:0] print_char,
    output logic          fifo_full,
    output logic          overflow,
    output logic          busy,
    output logic          wr_en,
    output logic [12:0]   wr_addr,
    output logic [CW-1:0] wr_char,
    output logic [6:0]    cur_col,
    output logic [5:0]    cur_row
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [12:0] CELLS    = 13'(COLS * ROWS);
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          push, pop, fifo_empty;
    logic [CW-1:0] cmd;
    logic          is_clear, is_newline, is_backspace;
    logic [12:0]   clr_addr, clr_addr_nxt;
    logic          wr_en_nxt;
    logic [12:0]   wr_addr_nxt;
    logic [CW-1:0] wr_char_nxt;
    logic [6:0]    col_nxt;
    logic [5:0]    row_nxt, row_inc;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push       = print_valid && !fifo_full;
    assign busy       = !fifo_empty || (state == CLEAR);
    assign row_inc    = (cur_row == LAST_ROW) ? '0 : cur_row + 6'd1;

    function automatic logic [12:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        return 13'(row) * 13'(COLS) + 13'(col);
    endfunction

`ifdef TEXT_CTRLCODE_EN
    assign is_clear     = (cmd == CW'(6'h3D));
    assign is_backspace = (cmd == CW'(6'h3E));
    assign is_newline   = (cmd == CW'(6'h3F));
`else
    assign is_clear     = 1'b0;
    assign is_backspace = 1'b0;
    assign is_newline   = 1'b0;
`endif

    // A strobe arriving while full is dropped even if a pop frees a slot on the same edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            if (print_valid && fifo_full) overflow <= 1'b1;
        end
    end

    // NOTE: the FIFO array has no reset; pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= print_char;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = EXEC;
            EXEC: begin
                if (is_clear)        state_nxt = CLEAR;
                else if (fifo_empty) state_nxt = IDLE;
            end
            CLEAR:   if (clr_addr == CELLS) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        pop          = 1'b0;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_char_nxt  = wr_char;
        col_nxt      = cur_col;
        row_nxt      = cur_row;
        clr_addr_nxt = clr_addr;
        case (state)
            IDLE: pop = !fifo_empty;
            EXEC: begin
                pop = !fifo_empty && !is_clear;
                if (is_clear) begin
                    clr_addr_nxt = '0;
                end else if (is_newline) begin
                    col_nxt = '0;
                    row_nxt = row_inc;
                end else if (is_backspace) begin
                    if (cur_col != '0) begin
                        col_nxt     = cur_col - 7'd1;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cell_addr(cur_row, cur_col - 7'd1);
                        wr_char_nxt = '0;
                    end else if (cur_row != '0) begin
                        col_nxt     = LAST_COL;
                        row_nxt     = cur_row - 6'd1;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cell_addr(cur_row - 6'd1, LAST_COL);
                        wr_char_nxt = '0;
                    end
                end else begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = cell_addr(cur_row, cur_col);
                    wr_char_nxt = cmd;
                    if (cur_col == LAST_COL) begin
                        col_nxt = '0;
                        row_nxt = row_inc;
                    end else begin
                        col_nxt = cur_col + 7'd1;
                    end
                end
            end
            CLEAR: begin
                if (clr_addr != CELLS) begin
                    wr_en_nxt    = 1'b1;
                    wr_addr_nxt  = clr_addr;
                    wr_char_nxt  = '0;
                    clr_addr_nxt = clr_addr + 13'd1;
                end else begin
                    col_nxt = '0;
                    row_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cmd      <= '0;
            clr_addr <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_char  <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
        end else begin
            if (pop) cmd <= fifo_mem[rd_ptr];
            clr_addr <= clr_addr_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_char  <= wr_char_nxt;
            cur_col  <= col_nxt;
            cur_row  <= row_nxt;
        end
    end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Randomized/directed bench for text_cursor_ctrl against a queue-based model tracking the cursor as a linear cell index.
// Follows TEXT_CTRLCODE_EN the same way the design does.
module tb_text_cursor_ctrl;
    localparam int COLS       = 80;
    localparam int ROWS       = 60;
    localparam int CELLS      = COLS * ROWS;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        clr;
    logic        print_valid;
    logic [5:0]  print_char;
    logic        fifo_full, overflow, busy, wr_en;
    logic [12:0] wr_addr;
    logic [5:0]  wr_char;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;

    text_cursor_ctrl dut (
        .clk(clk), .clr(clr), .print_valid(print_valid), .print_char(print_char),
        .fifo_full(fifo_full), .overflow(overflow), .busy(busy), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_char(wr_char), .cur_col(cur_col), .cur_row(cur_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int last_addr, last_char;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: FIFO as a queue, cursor as a linear index pos = row*COLS + col.
    int mq[$];
    bit m_have_cmd;
    int m_cmd;
    int m_clear_step;   // -1: not clearing; 0..CELLS-1: next cell to blank; CELLS: final return cycle
    int m_pos;
    bit m_ovf, m_we;
    int m_addr, m_chr;

    function automatic bit ctrl_en();
`ifdef TEXT_CTRLCODE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_have_cmd = 0; m_cmd = 0; m_clear_step = -1;
        m_pos = 0; m_ovf = 0; m_we = 0; m_addr = 0; m_chr = 0;
    endtask

    task automatic model_exec(input int c);
        if (ctrl_en() && c == 'h3F) begin
            m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
        end else if (ctrl_en() && c == 'h3E) begin
            if (m_pos > 0) begin
                m_pos--;
                m_we = 1; m_addr = m_pos; m_chr = 0;
            end
        end else if (ctrl_en() && c == 'h3D) begin
            m_clear_step = 0;
        end else begin
            m_we = 1; m_addr = m_pos; m_chr = c;
            m_pos = (m_pos + 1) % CELLS;
        end
    endtask

    task automatic model_step(input bit valid, input int ch);
        bit push_ok;
        push_ok = valid && (mq.size() < FIFO_DEPTH);
        if (valid && !push_ok) m_ovf = 1;
        m_we = 0;
        if (m_clear_step >= 0) begin
            if (m_clear_step < CELLS) begin
                m_we = 1; m_addr = m_clear_step; m_chr = 0;
                m_clear_step++;
            end else begin
                m_pos = 0;
                m_clear_step = -1;
            end
        end else if (m_have_cmd) begin
            model_exec(m_cmd);
            m_have_cmd = 0;
            if (m_clear_step < 0 && mq.size() > 0) begin
                m_cmd = mq.pop_front();
                m_have_cmd = 1;
            end
        end else if (mq.size() > 0) begin
            m_cmd = mq.pop_front();
            m_have_cmd = 1;
        end
        if (push_ok) mq.push_back(ch);
    endtask

    task automatic compare_all();
        check("wr_en", wr_en, m_we);
        if (m_we) begin
            check("wr_addr", wr_addr, m_addr);
            check("wr_char", wr_char, m_chr);
        end
        check("cur_col", cur_col, m_pos % COLS);
        check("cur_row", cur_row, m_pos / COLS);
        check("fifo_full", fifo_full, mq.size() == FIFO_DEPTH);
        check("busy", busy, (mq.size() > 0) || (m_clear_step >= 0));
        check("overflow", overflow, m_ovf);
    endtask

    task automatic tick(input bit valid, input int ch);
        print_valid = valid;
        print_char  = 6'(ch);
        @(posedge clk);
        model_step(valid, ch);
        #1;
        compare_all();
        if (wr_en) begin
            n_wr++;
            last_addr = int'(wr_addr);
            last_char = int'(wr_char);
        end
        print_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (busy && guard < 6000) begin
            tick(0, 0);
            guard++;
        end
        check("drain_timeout", busy, 0);
        idle(2);
    endtask

    initial begin
        int w0, need, ch;
        clr = 1'b0; print_valid = 1'b0; print_char = '0;
        model_reset();
        #2;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_char", wr_char, 0);
        check("rst_col", cur_col, 0);
        check("rst_row", cur_row, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        #1 clr = 1'b1;

        // First print: write lands two edges after the strobe.
        tick(1, 'h01);
        tick(0, 0);
        check("A_early", n_wr, 0);
        tick(0, 0);
        check("A_wr_en", wr_en, 1);
        check("A_addr", wr_addr, 0);
        check("A_char", wr_char, 'h01);
        check("A_col", cur_col, 1);

        // Row wrap: 79 + 1 back-to-back printables.
        for (int i = 0; i < 80; i++) tick(1, $urandom_range(1, 60));
        drain();
        check("wrap_last_addr", last_addr, 80);
        check("wrap_col", cur_col, 1);
        check("wrap_row", cur_row, 1);

        // Move to (5,2), then newline and backspace.
        for (int i = 0; i < 84; i++) tick(1, $urandom_range(1, 60));
        drain();
        check("pos_col", cur_col, 5);
        check("pos_row", cur_row, 2);
        w0 = n_wr;
        tick(1, 'h3F);
        drain();
        if (ctrl_en()) begin
            check("nl_no_write", n_wr - w0, 0);
            check("nl_col", cur_col, 0);
            check("nl_row", cur_row, 3);
        end
        tick(1, 'h3E);
        drain();
        if (ctrl_en()) begin
            check("bs_addr", last_addr, 239);
            check("bs_char", last_char, 0);
        end

        // Cursor to (40,30), then clear with a 10-strobe burst behind it.
        need = (30 * COLS + 40 - m_pos + CELLS) % CELLS;
        for (int i = 0; i < need; i++) tick(1, $urandom_range(1, 60));
        drain();
        check("cl_pre_col", cur_col, 40);
        check("cl_pre_row", cur_row, 30);
        w0 = n_wr;
        tick(1, 'h3D);
        for (int i = 0; i < 10; i++) tick(1, $urandom_range(1, 60));
        drain();
        if (ctrl_en()) begin
            check("cl_overflow", overflow, 1);
            check("cl_writes", n_wr - w0, CELLS + 8);
            check("cl_col", cur_col, 8);
            check("cl_row", cur_row, 0);
        end

        // Abort mid-clear with an asynchronous reset.
        tick(1, 'h3D);
        idle(1002);
        #3 clr = 1'b0;
        #1;
        model_reset();
        check("abort_wr_en", wr_en, 0);
        check("abort_col", cur_col, 0);
        check("abort_row", cur_row, 0);
        check("abort_busy", busy, 0);
        check("abort_overflow", overflow, 0);
        @(posedge clk);
        #2 clr = 1'b1;
        w0 = n_wr;
        idle(20);
        check("abort_quiet", n_wr - w0, 0);

        // Random traffic (no clears, to keep the run short).
        for (int i = 0; i < 3000; i++) begin
            ch = $urandom_range(0, 63);
            if (ch == 'h3D) ch = 'h3E;
            tick($urandom_range(0, 2) == 0, ch);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
